// File: rtl/spi_burst_master_bmm150.sv
// SPI master for BMM150-style register-mapped sensors: one {rw, addr} command byte
// followed by 1..MAX_LEN data bytes inside a single cs_n frame, SPI mode 0 or 3.
//
//   state | meaning
//   IDLE  | cs_n high, sclk at CPOL, waiting for start
//   SETUP | cs_n low for DIV cycles before the first sclk edge
//   SHIFT | 8*(1+len) bits, each a low half then a high half of DIV cycles
//   HOLD  | cs_n low for DIV cycles after the last bit, sclk at CPOL
//   GAP   | cs_n high for DIV cycles, done pulses in the first one
module spi_burst_master_bmm150 #(
  parameter int  CLK_HZ  = 50_000_000,
  parameter int  SPI_CLK = 5_000_000,
  parameter int  MAX_LEN = 8,
  parameter bit  CPOL    = 1'b1,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          rw,
  input  logic [6:0]    reg_addr,
  input  logic [LW-1:0] len,
  input  logic [7:0]    tx_data,
  output logic          tx_ack,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          sclk,
  output logic          mosi,
  output logic          cs_n,
  input  logic          miso
);

  localparam int            DIV     = CLK_HZ / (2 * SPI_CLK);
  localparam int            DW      = $clog2(DIV);
  localparam logic [DW-1:0] DIV_TOP = DW'(DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic          half;
  logic [2:0]    bit_cnt;
  logic [LW-1:0] byte_cnt, len_q;
  logic          rw_q;
  logic [7:0]    shreg;
  logic [6:0]    rx_sh;

  logic len_ok, accept, div_tc, bit_end, byte_end, last_byte, load_next, rise;

  assign len_ok    = (len != '0) && (len <= LW'(MAX_LEN));
  assign accept    = (state == S_IDLE) && start && len_ok;
  assign div_tc    = (div_cnt == '0);
  assign bit_end   = (state == S_SHIFT) && half && div_tc;
  assign byte_end  = bit_end && (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == len_q);
  assign load_next = byte_end && !last_byte;
  // first clk cycle of each high half is the sclk rising edge
  assign rise      = (state == S_SHIFT) && half && (div_cnt == DIV_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SETUP;
      S_SETUP: if (div_tc) state_nxt = S_SHIFT;
      S_SHIFT: if (byte_end && last_byte) state_nxt = S_HOLD;
      S_HOLD:  if (div_tc) state_nxt = S_GAP;
      S_GAP:   if (div_tc) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cs_n = 1'b1;
    sclk = CPOL;
    mosi = 1'b1;
    busy = 1'b1;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_SETUP: begin
        cs_n = 1'b0;
        mosi = CPOL ? 1'b1 : shreg[7];
      end
      S_SHIFT: begin
        cs_n = 1'b0;
        sclk = half;
        mosi = shreg[7];
      end
      S_HOLD: begin
        cs_n = 1'b0;
        mosi = shreg[7];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= DIV_TOP;
      half     <= 1'b0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      len_q    <= '0;
      rw_q     <= 1'b0;
      shreg    <= 8'hFF;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // every non-IDLE state leaves on terminal count, so reload there covers entry too
      if (state == S_IDLE || div_tc) div_cnt <= DIV_TOP;
      else                           div_cnt <= div_cnt - DW'(1);

      if (state != S_SHIFT) half <= 1'b0;
      else if (div_tc)      half <= ~half;

      if (state != S_SHIFT) bit_cnt <= '0;
      else if (bit_end)     bit_cnt <= bit_cnt + 3'd1;

      if (state != S_SHIFT) byte_cnt <= '0;
      else if (load_next)   byte_cnt <= byte_cnt + LW'(1);

      if (accept) begin
        rw_q  <= rw;
        len_q <= len;
      end

      if (accept)                          shreg <= {rw, reg_addr};
      else if (load_next)                  shreg <= rw_q ? 8'hFF : tx_data;
      else if (bit_end && bit_cnt != 3'd7) shreg <= {shreg[6:0], 1'b1};

      if (rise) rx_sh <= {rx_sh[5:0], miso};

      rx_valid <= rise && (bit_cnt == 3'd7) && (byte_cnt != '0) && rw_q;
      if (rise && (bit_cnt == 3'd7) && (byte_cnt != '0) && rw_q)
        rx_data <= {rx_sh, miso};

      tx_ack <= load_next && !rw_q;
      done   <= (state == S_HOLD) && div_tc;
      err    <= (state == S_IDLE) && start && !len_ok;
    end
  end

endmodule

// File: doc/spi_burst_master_bmm150.md
# spi_burst_master_bmm150

Parametrised SPI master for the BMM150 magnetometer and similar register-mapped SPI sensors. It runs one command byte ({rw, addr}) followed by 1..MAX_LEN data bytes inside a single chip-select frame, which gives burst reads of the data registers (0x42..0x49) and multi-byte writes. It sits between the sensor-polling controller and the SPI pins, streams bytes through pulse handshakes, and supports SPI mode 0 and mode 3.

## Interface
- CLK_HZ, 50_000_000, system clock frequency (Hz)
- SPI_CLK, 5_000_000, SCLK frequency (Hz); DIV = CLK_HZ/(2*SPI_CLK), legal only if DIV >= 2
- MAX_LEN, 8, maximum data bytes per frame; LW = $clog2(MAX_LEN+1)
- CPOL, 1, SCLK idle level: 1 = mode 3, 0 = mode 0 (CPHA is fixed: sample on rising, shift on falling)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame request, accepted only in IDLE
- rw  in  1  1 = read, 0 = write; sampled at accept
- reg_addr  in  7  start register; sampled at accept
- len  in  LW  data byte count; sampled at accept
- tx_data  in  8  write byte; sampled when each write data byte is loaded
- tx_ack  out  1  pulse: tx_data has been captured, host must present the next byte
- rx_data  out  8  last received byte; held until the next update
- rx_valid  out  1  pulse: rx_data updated
- busy  out  1  high from the cycle after accept until the GAP state ends
- done  out  1  one-cycle pulse when cs_n rises
- err  out  1  one-cycle pulse when start is given with len==0 or len>MAX_LEN
- sclk, mosi, cs_n  out  1  SPI pins; miso  in  1

## Operation
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: cs_n=1, sclk=CPOL, mosi=1. On start:
  - If len is legal: latch rw, reg_addr and len; load the shift register with {rw, reg_addr}; go to SETUP.
  - If len is illegal: pulse err next cycle and stay in IDLE.
- SETUP lasts DIV cycles. cs_n=0, sclk=CPOL. In mode 0, mosi presents bit 7 from SETUP entry.
- SHIFT covers 8*(1+len) bits, MSB first, command byte first. Each bit is a low half of DIV cycles followed by a high half of DIV cycles.
  - mosi changes only on the sclk falling edge. In mode 3 the first falling edge opens the SHIFT state; in mode 0 SETUP has already presented bit 7.
  - miso is sampled in the clk cycle of each sclk rising edge.
  - Mode 0 ends SHIFT with sclk falling back to 0 at the end of the last high half.
- Write data bytes:
  - tx_data is loaded into the shift register at the start of each data byte.
  - tx_ack pulses in that same cycle.
  - The host has 16*DIV cycles to present the next byte.
- Read data bytes:
  - mosi=1 throughout; tx_ack never pulses.
  - After the 8th rising edge of each data byte, rx_data takes the assembled byte and rx_valid pulses the next cycle.
  - The command byte never produces rx_valid. Write frames never produce rx_valid.
- HOLD: DIV cycles, cs_n=0, sclk=CPOL.
- GAP: cs_n=1, done pulses in its first cycle, lasts DIV cycles, then IDLE.
- start is ignored while busy=1, including during GAP.
- The block never changes the address. Any sensor-side auto-increment is transparent to it.

## Timing
- Reset values: cs_n=1, sclk=CPOL, mosi=1, busy=0, done=0, err=0, tx_ack=0, rx_valid=0, rx_data=0x00, state=IDLE.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). No done pulse and no partial rx_valid.
- Accept to cs_n fall: 1 cycle.
- cs_n low duration: DIV*(2 + 16*(1+len)) cycles.
- done to next possible accept: DIV cycles.
- Counters:
  - Divider counter width is $clog2(DIV).
  - Bit counter counts 0..7 and wraps.
  - Byte counter counts 0..len.
  - No counter may overflow at len = MAX_LEN.
- start in the same cycle as done: ignored (busy=1).

## Test plan
- Read len=1, addr 0x40, miso model returns 0x32 -> MOSI shows 0xC0; one rx_valid with rx_data=0x32; done; cs_n low for exactly DIV*34 cycles.
- Write len=1, addr 0x4B, tx_data 0x01 -> MOSI shows 0x4B then 0x01; one tx_ack; no rx_valid; done.
- Burst read len=8 from 0x42, model returns 0x10..0x17 -> 8 rx_valid pulses in order 0x10..0x17; a single cs_n low window.
- start with len=0, then with len=MAX_LEN+1 -> err pulse each time; cs_n stays 1; busy stays 0.
- start pulsed mid-frame and again in the done cycle -> ignored; frame unchanged; a start after GAP is accepted.
- rst_n low during the 2nd data bit of a burst read -> cs_n=1, sclk=CPOL, mosi=1 immediately; no rx_valid; a following frame completes normally. Repeat the full suite with CPOL=0.
